// File: rtl/dvp_src_pkg.sv
// rtl/dvp_src_pkg.sv - shared types and constants for the DVP frame source
package dvp_src_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_HFP,
    ST_ACT,
    ST_HBL,
    ST_VFP
  } state_t;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRAD  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_EXT   = 2'd3;

  // RGB565 colour bars, index 0 is the leftmost bar
  localparam logic [0:7][15:0] BAR_COLOUR = {
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/dvp_frame_source_if.sv
// rtl/dvp_frame_source_if.sv - DVP output bus plus external pixel handshake
interface dvp_frame_source_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PIXEL_W    = 16
);
  logic [PIXEL_W-1:0]    pixel_i;
  logic                  valid_i;
  logic                  ready_o;
  logic                  vsync_o;
  logic                  href_o;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (
    input  pixel_i, valid_i,
    output ready_o, vsync_o, href_o, data_o
  );

  modport slave (
    output pixel_i, valid_i,
    input  ready_o, vsync_o, href_o, data_o
  );
endinterface

// File: rtl/dvp_pattern_gen.sv
// rtl/dvp_pattern_gen.sv - combinational built-in test pattern per pixel position
module dvp_pattern_gen
  import dvp_src_pkg::*;
#(
  parameter int PIXEL_W = 16
) (
  input  logic [15:0]        x,
  input  logic               y3,
  input  logic [1:0]         mode,
  input  logic [2:0]         bar,
  output logic [PIXEL_W-1:0] pixel
);
  logic [15:0] val;

  always_comb begin
    val = 16'h0000;
    case (mode)
      MODE_BARS:  val = BAR_COLOUR[bar];
      MODE_GRAD:  val = x;
      MODE_CHECK: val = (x[3] ^ y3) ? 16'hFFFF : 16'h0000;
      default:    val = 16'h0000;
    endcase
  end

  // Patterns are 16-bit values placed in the pixel LSBs
  generate
    if (PIXEL_W > 16) begin : g_ext
      assign pixel = {{(PIXEL_W-16){1'b0}}, val};
    end else if (PIXEL_W == 16) begin : g_eq
      assign pixel = val;
    end else begin : g_trunc
      assign pixel = val[PIXEL_W-1:0];
    end
  endgenerate
endmodule

// File: rtl/dvp_frame_source.sv
// rtl/dvp_frame_source.sv - DVP camera emulator: frame timing FSM and byte serialiser
module dvp_frame_source
  import dvp_src_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int LINE_TOTAL      = 1896,
  parameter int H_FRONT         = 20,
  parameter int VSYNC_LINES     = 3,
  parameter int V_BACK_LINES    = 10,
  parameter int V_FRONT_LINES   = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [15:0] frames_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] width_i,
  input  logic [15:0] height_i,
  dvp_frame_source_if.master dvp,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] frame_cnt_o,
  output logic        error_o
);
  localparam int PIXEL_W = DATA_WIDTH * BYTES_PER_PIXEL;
  localparam logic [31:0] VS_LEN    = 32'(VSYNC_LINES * LINE_TOTAL);
  localparam logic [31:0] VBP_LEN   = 32'(V_BACK_LINES * LINE_TOTAL);
  localparam logic [31:0] VFP_LEN   = 32'(V_FRONT_LINES * LINE_TOTAL);
  localparam logic [31:0] LT32      = 32'(LINE_TOTAL);
  localparam logic [31:0] HF32      = 32'(H_FRONT);
  localparam logic [31:0] BPP32     = 32'(BYTES_PER_PIXEL);
  localparam logic [1:0]  BEAT_LAST = 2'(BYTES_PER_PIXEL - 1);

  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] x_q, x_d, y_q, y_d, bpos_q, bpos_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] frames_q, frames_d, width_q, width_d, height_q, height_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        stop_q, stop_d, stop_now;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;
  logic        vsync_q, vsync_d, href_q, href_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PIXEL_W-1:0]    sh_q, sh_d, gen_pixel, pix_new;
  logic        load_d, geom_bad;
  logic [31:0] act_len, hbl_len;
  logic [15:0] bar_w;

  assign act_len  = {16'd0, width_q} * BPP32;
  assign hbl_len  = LT32 - HF32 - act_len;
  assign bar_w    = {3'd0, width_q[15:3]};
  assign geom_bad = (width_i == 16'd0) || (height_i == 16'd0) ||
                    (({16'd0, width_i} * BPP32) > (LT32 - HF32 - 32'd1));
  assign stop_now = stop_q | stop_i;

  dvp_pattern_gen #(.PIXEL_W(PIXEL_W)) u_pattern (
    .x     (x_d),
    .y3    (y_d[3]),
    .mode  (mode_q),
    .bar   (bar_d),
    .pixel (gen_pixel)
  );

  assign pix_new = (mode_q == MODE_EXT) ? (dvp.valid_i ? dvp.pixel_i : '0) : gen_pixel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    beat_d      = beat_q;
    bar_d       = bar_q;
    bpos_d      = bpos_q;
    frames_d    = frames_q;
    mode_d      = mode_q;
    width_d     = width_q;
    height_d    = height_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = (state_q != ST_IDLE) && stop_now;
    err_d       = err_q;
    done_d      = 1'b0;
    load_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (geom_bad) begin
            err_d = 1'b1;
          end else begin
            frames_d    = frames_i;
            mode_d      = mode_i;
            width_d     = width_i;
            height_d    = height_i;
            frame_cnt_d = 16'd0;
            err_d       = 1'b0;
            stop_d      = 1'b0;
            state_d     = ST_VSYNC;
            cnt_d       = VS_LEN - 32'd1;
          end
        end
      end
      default: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
          if (state_q == ST_ACT) begin
            if (beat_q == BEAT_LAST) begin
              beat_d = 2'd0;
              x_d    = x_q + 16'd1;
              load_d = 1'b1;
              if (bpos_q == bar_w - 16'd1) begin
                bpos_d = 16'd0;
                bar_d  = bar_q + 3'd1;
              end else begin
                bpos_d = bpos_q + 16'd1;
              end
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end
        end else begin
          case (state_q)
            ST_VSYNC: begin
              state_d = ST_VBP;
              cnt_d   = VBP_LEN - 32'd1;
            end
            ST_VBP: begin
              state_d = ST_HFP;
              cnt_d   = HF32 - 32'd1;
              y_d     = 16'd0;
            end
            ST_HFP: begin
              state_d = ST_ACT;
              cnt_d   = act_len - 32'd1;
              x_d     = 16'd0;
              beat_d  = 2'd0;
              bar_d   = 3'd0;
              bpos_d  = 16'd0;
              load_d  = 1'b1;
            end
            ST_ACT: begin
              state_d = ST_HBL;
              cnt_d   = hbl_len - 32'd1;
            end
            ST_HBL: begin
              if (y_q == height_q - 16'd1) begin
                state_d = ST_VFP;
                cnt_d   = VFP_LEN - 32'd1;
              end else begin
                state_d = ST_HFP;
                cnt_d   = HF32 - 32'd1;
                y_d     = y_q + 16'd1;
              end
            end
            ST_VFP: begin
              frame_cnt_d = frame_cnt_q + 16'd1;
              // A stop request and the final counted frame collapse into one exit
              if (((frames_q != 16'd0) && ((frame_cnt_q + 16'd1) == frames_q)) || stop_now) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                stop_d  = 1'b0;
              end else begin
                state_d = ST_VSYNC;
                cnt_d   = VS_LEN - 32'd1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase

    if (load_d && (mode_q == MODE_EXT) && !dvp.valid_i) begin
      err_d = 1'b1;
    end

    vsync_d = (state_d == ST_IDLE) || (state_d == ST_VSYNC) || (state_d == ST_VFP);
    href_d  = (state_d == ST_ACT);
    sh_d    = sh_q;
    data_d  = '0;
    if (load_d) begin
      data_d = pix_new[PIXEL_W-1 -: DATA_WIDTH];
      sh_d   = pix_new << DATA_WIDTH;
    end else if (state_d == ST_ACT) begin
      data_d = sh_q[PIXEL_W-1 -: DATA_WIDTH];
      sh_d   = sh_q << DATA_WIDTH;
    end

    // Armed one tick ahead so the source sees ready in the cycle whose ce edge captures beat 0
    rdy_d = (mode_d == MODE_EXT) &&
            (((state_d == ST_HFP) && (cnt_d == 32'd0)) ||
             ((state_d == ST_ACT) && (cnt_d != 32'd0) && (beat_d == BEAT_LAST)));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      beat_q      <= 2'd0;
      bar_q       <= 3'd0;
      bpos_q      <= 16'd0;
      frames_q    <= 16'd0;
      mode_q      <= MODE_BARS;
      width_q     <= 16'd0;
      height_q    <= 16'd0;
      frame_cnt_q <= 16'd0;
      stop_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b0;
      vsync_q     <= 1'b1;
      href_q      <= 1'b0;
      data_q      <= '0;
      sh_q        <= '0;
    end else begin
      done_q <= ce_i && done_d;
      if (ce_i) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        x_q         <= x_d;
        y_q         <= y_d;
        beat_q      <= beat_d;
        bar_q       <= bar_d;
        bpos_q      <= bpos_d;
        frames_q    <= frames_d;
        mode_q      <= mode_d;
        width_q     <= width_d;
        height_q    <= height_d;
        frame_cnt_q <= frame_cnt_d;
        stop_q      <= stop_d;
        err_q       <= err_d;
        rdy_q       <= rdy_d;
        vsync_q     <= vsync_d;
        href_q      <= href_d;
        data_q      <= data_d;
        sh_q        <= sh_d;
      end else if (stop_i && (state_q != ST_IDLE)) begin
        stop_q <= 1'b1;
      end
    end
  end

  assign dvp.ready_o = rdy_q & ce_i;
  assign dvp.vsync_o = vsync_q;
  assign dvp.href_o  = href_q;
  assign dvp.data_o  = data_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;
  assign error_o     = err_q;
endmodule

// File: tb/tb_dvp_frame_source.sv
// tb/tb_dvp_frame_source.sv - self-checking bench for dvp_frame_source
module tb_dvp_frame_source;
  localparam int DW = 8, BPP = 2, LT = 24, HF = 2, VS = 1, VBP = 1, VFP = 1;

  logic tb_vgaClock = 1'b0;
  always #5 tb_vgaClock = ~tb_vgaClock;

  logic        reset, ce, start, stop;
  logic [15:0] frames, width, height;
  logic [1:0]  mode;
  logic        busy, done, error;
  logic [15:0] frame_cnt;

  dvp_frame_source_if #(.DATA_WIDTH(DW), .PIXEL_W(DW*BPP)) dvp ();

  dvp_frame_source #(
    .DATA_WIDTH(DW), .BYTES_PER_PIXEL(BPP), .LINE_TOTAL(LT), .H_FRONT(HF),
    .VSYNC_LINES(VS), .V_BACK_LINES(VBP), .V_FRONT_LINES(VFP)
  ) dut (
    .clk_i(tb_vgaClock), .reset_i(reset), .ce_i(ce), .start_i(start), .stop_i(stop),
    .frames_i(frames), .mode_i(mode), .width_i(width), .height_i(height),
    .dvp(dvp), .busy_o(busy), .done_o(done), .frame_cnt_o(frame_cnt), .error_o(error)
  );

  int checks = 0, passed = 0;
  int m_w, m_h, m_mode, m_drop;
  logic [15:0] ext_pix [0:511];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] exp_pixel(int f, int x, int y);
    int n;
    case (m_mode)
      0: return bars[x / (m_w / 8)];
      1: return 16'(x);
      2: return (((x >> 3) ^ (y >> 3)) & 1) ? 16'hFFFF : 16'h0000;
      default: begin
        n = (f * m_h + y) * m_w + x;
        return (n == m_drop) ? 16'h0000 : ext_pix[n];
      end
    endcase
  endfunction

  // {busy, vsync, href, data} expected on tick t after start
  function automatic logic [10:0] exp_word(int t, int total);
    int ft, r, l, h, f, x, y, k;
    logic [15:0] p;
    ft = (VS + VBP + m_h + VFP) * LT;
    if (t >= total) return {1'b0, 1'b1, 1'b0, 8'h00};
    f = t / ft; r = t % ft; l = r / LT; h = r % LT;
    if (l >= VS + VBP && l < VS + VBP + m_h && h >= HF && h < HF + m_w * BPP) begin
      y = l - VS - VBP; x = (h - HF) / BPP; k = (h - HF) % BPP;
      p = exp_pixel(f, x, y);
      return {1'b1, 1'b0, 1'b1, (k == 0) ? p[15:8] : p[7:0]};
    end
    return {1'b1, (l < VS || l >= VS + VBP + m_h), 1'b0, 8'h00};
  endfunction

  task automatic run_stream(input string name, input int fr_in, input int md, input int w,
                            input int h, input bit ce_tog, input int nframes,
                            input int stop_at, input int start_at, input int drop);
    int t, cyc, bad, first_t, done_cnt, done_t, rdy_cnt, idx, total;
    logic [10:0] obs, expw, prev, bad_obs, bad_exp;
    bit last_ce;
    m_w = w; m_h = h; m_mode = md; m_drop = drop;
    total = nframes * (VS + VBP + h + VFP) * LT;
    for (int i = 0; i < 512; i++) ext_pix[i] = 16'($urandom);
    @(negedge tb_vgaClock);
    frames = 16'(fr_in); mode = 2'(md); width = 16'(w); height = 16'(h);
    start = 1'b1; ce = 1'b1; dvp.valid_i = 1'b0; dvp.pixel_i = 16'h0;
    last_ce = 1'b1; t = 0; cyc = 0; bad = 0; first_t = -1; done_cnt = 0; done_t = -1;
    rdy_cnt = 0; idx = 0; prev = '0; bad_obs = '0; bad_exp = '0;
    while (t <= total + 1 && cyc < 20000) begin
      @(negedge tb_vgaClock);
      cyc++; start = 1'b0; stop = 1'b0;
      obs = {busy, dvp.vsync_o, dvp.href_o, dvp.data_o};
      if (last_ce) begin
        expw = exp_word(t, total);
        if (obs !== expw) begin
          if (bad == 0) begin first_t = t; bad_obs = obs; bad_exp = expw; end
          bad++;
        end
        if (done) begin done_cnt++; done_t = t; end
        t++;
      end else begin
        if (obs !== prev) begin
          if (bad == 0) begin first_t = t; bad_obs = obs; bad_exp = prev; end
          bad++;
        end
        if (done) done_cnt++;
      end
      prev = obs;
      if (last_ce && t == stop_at) stop = 1'b1;
      if (last_ce && t == start_at) begin start = 1'b1; mode = 2'(md ^ 1); end
      ce = ce_tog ? !ce : 1'b1;
      last_ce = ce;
      dvp.pixel_i = ext_pix[idx];
      dvp.valid_i = (idx != drop);
      #1;
      if (dvp.ready_o && idx < 511) begin rdy_cnt++; idx++; end
    end
    start = 1'b0; stop = 1'b0; ce = 1'b1;
    checks++;
    if (t <= total + 1) $display("FAIL %s timeout: reached tick %0d required %0d", name, t, total + 2);
    else passed++;
    checks++;
    if (bad !== 0) $display("FAIL %s stream: %0d bad ticks, first at %0d got %h expected %h", name, bad, first_t, bad_obs, bad_exp);
    else passed++;
    checks++;
    if (done_cnt !== 1 || done_t !== total) $display("FAIL %s done: %0d pulses at tick %0d expected 1 at %0d", name, done_cnt, done_t, total);
    else passed++;
    checks++;
    if (frame_cnt !== 16'(nframes)) $display("FAIL %s frame_cnt: got %0d expected %0d", name, frame_cnt, nframes);
    else passed++;
    checks++;
    if (rdy_cnt !== ((md == 3) ? w * h * nframes : 0)) $display("FAIL %s ready: got %0d expected %0d", name, rdy_cnt, (md == 3) ? w * h * nframes : 0);
    else passed++;
    checks++;
    if (error !== ((md == 3 && drop >= 0) ? 1'b1 : 1'b0)) $display("FAIL %s error: got %b expected %b", name, error, (md == 3 && drop >= 0));
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; start = 1'b0; stop = 1'b0;
    frames = 16'd1; mode = 2'd1; width = 16'd8; height = 16'd4;
    dvp.pixel_i = 16'h0; dvp.valid_i = 1'b0;
    repeat (3) @(negedge tb_vgaClock);
    checks++;
    if ({dvp.vsync_o, dvp.href_o, dvp.data_o, dvp.ready_o} !== {1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL reset bus: got %b%b %h %b expected 1 0 00 0", dvp.vsync_o, dvp.href_o, dvp.data_o, dvp.ready_o);
    else passed++;
    checks++;
    if ({busy, done, error, frame_cnt} !== {1'b0, 1'b0, 1'b0, 16'd0})
      $display("FAIL reset status: got %b%b%b %h expected 000 0000", busy, done, error, frame_cnt);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_bad_geometry();
    int ws [4] = '{12, 11, 0, 4};
    int hs [4] = '{4, 4, 4, 0};
    for (int i = 0; i < 4; i++) begin
      reset = 1'b1;
      @(negedge tb_vgaClock);
      reset = 1'b0; width = 16'(ws[i]); height = 16'(hs[i]); start = 1'b1; ce = 1'b1;
      @(negedge tb_vgaClock);
      start = 1'b0;
      checks++;
      if ({error, busy} !== 2'b10) $display("FAIL geometry w%0d h%0d: error/busy got %b%b expected 10", ws[i], hs[i], error, busy);
      else passed++;
    end
  endtask

  task automatic test_reset_midline();
    int n;
    @(negedge tb_vgaClock);
    frames = 16'd1; mode = 2'd1; width = 16'd8; height = 16'd4; start = 1'b1; ce = 1'b1;
    n = 0;
    do begin @(negedge tb_vgaClock); start = 1'b0; n++; end while (!(dvp.href_o && dvp.data_o == 8'h03) && n < 400);
    checks++;
    if (n >= 400) $display("FAIL midline wait: href never seen within %0d cycles", n);
    else passed++;
    reset = 1'b1;
    @(negedge tb_vgaClock);
    reset = 1'b0;
    checks++;
    if ({dvp.vsync_o, dvp.href_o, dvp.data_o, busy, frame_cnt, error} !== {1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0})
      $display("FAIL midline reset: got v%b h%b d%h b%b fc%0d e%b expected v1 h0 d00 b0 fc0 e0", dvp.vsync_o, dvp.href_o, dvp.data_o, busy, frame_cnt, error);
    else passed++;
    repeat (30) @(negedge tb_vgaClock);
    checks++;
    if ({busy, dvp.href_o, done} !== 3'b000) $display("FAIL midline idle: busy/href/done got %b%b%b expected 000", busy, dvp.href_o, done);
    else passed++;
  endtask

  task automatic test_random();
    int md, w, h, nf;
    for (int i = 0; i < 5; i++) begin
      md = $urandom_range(0, 2);
      w  = (md == 0) ? 8 : $urandom_range(1, 10);
      h  = $urandom_range(1, 5);
      nf = $urandom_range(1, 2);
      run_stream($sformatf("random%0d", i), nf, md, w, h, 1'($urandom_range(0, 1)), nf, -1, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    run_stream("gradient", 1, 1, 8, 4, 1'b0, 1, -1, -1, -1);
    run_stream("colour_bars", 1, 0, 8, 4, 1'b0, 1, -1, -1, -1);
    run_stream("ce_half_rate", 1, 1, 8, 4, 1'b1, 1, -1, -1, -1);
    run_stream("checker_w10", 1, 2, 10, 5, 1'b0, 1, -1, -1, -1);
    run_stream("stop_free_run", 0, 1, 8, 4, 1'b0, 3, 2 * 168 + 50, 168 + 30, -1);
    run_stream("stop_last_frame", 2, 2, 8, 4, 1'b0, 2, 2 * 168, -1, -1);
    run_stream("external_underflow", 1, 3, 8, 4, 1'b0, 1, -1, -1, 5);
    run_stream("back_to_back_ext", 2, 3, 6, 3, 1'b1, 2, -1, -1, -1);
    test_bad_geometry();
    test_reset_midline();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
